pipe_field_logic: RTL and testbench

//  Multi-pipe successor to the single-obstacle game FSM. Tracks NUM_PIPES scrolling pipe

---
 rtl/pipe_field_logic_pkg.sv | 33 +++
 rtl/pipe_field_logic_if.sv | 31 +++
 rtl/pipe_field_logic_lfsr.sv | 25 ++
 rtl/pipe_field_logic.sv | 157 +++++++++++++++
 tb/tb_pipe_field_logic.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_field_logic_pkg.sv
// Shared state encoding, coordinate widths and LFSR constants
// for the scrolling pipe field.
package pipe_field_pkg;

  typedef enum logic [3:0] {
    ST_INIT  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_CHECK = 4'b0100,
    ST_LOSE  = 4'b1000
  } state_e;

  localparam int X_W = 11;
  localparam int Y_W = 10;
  localparam int C_W = 12;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

  // Pipe X lives in an 11-bit field whose window is
  // [-128, 1919]: only the top 128 codes read as negative,
  // so the 1120 start position of pipe 2 still fits.
  function automatic logic signed [C_W-1:0] x_dec(
    input logic [X_W-1:0] x
  );
    return (&x[10:7]) ? {1'b1, x} : {1'b0, x};
  endfunction

endpackage

// File: rtl/pipe_field_logic_if.sv
// Bus between bird physics / renderer and the pipe field.
// master drives Start/Ack/Tick/Bird_*, slave drives status.
interface pipe_field_logic_if #(
  parameter int NUM_PIPES = 3
);
  logic                      Start;
  logic                      Ack;
  logic                      Tick;
  logic signed [9:0]         Bird_X;
  logic signed [9:0]         Bird_Y;
  logic                      Q_Initial;
  logic                      Q_Run;
  logic                      Q_Check;
  logic                      Q_Lose;
  logic                      Lose;
  logic [7:0]                Score;
  logic [11*NUM_PIPES-1:0]   Pipe_X;
  logic [10*NUM_PIPES-1:0]   Gap_Y;

  modport master (
    output Start, Ack, Tick, Bird_X, Bird_Y,
    input  Q_Initial, Q_Run, Q_Check, Q_Lose,
    input  Lose, Score, Pipe_X, Gap_Y
  );

  modport slave (
    input  Start, Ack, Tick, Bird_X, Bird_Y,
    output Q_Initial, Q_Run, Q_Check, Q_Lose,
    output Lose, Score, Pipe_X, Gap_Y
  );
endinterface

// File: rtl/pipe_field_logic_lfsr.sv
// 16-bit Fibonacci LFSR with enable and sync reset to seed.
// Ports: Clk, reset, en_i, rnd_o (low OUT_W state bits).
module pipe_lfsr
  import pipe_field_pkg::*;
#(
  parameter int OUT_W = 7
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [OUT_W-1:0] rnd_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge Clk) begin
    if (reset)
      lfsr_q <= LFSR_SEED;
    else if (en_i)
      lfsr_q <= {lfsr_q[14:0], lfsr_fb(lfsr_q)};
  end

  assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/pipe_field_logic.sv
// Scrolling pipe field: FSM, pipe array, collision, score.
// Ports: Clk, reset (sync, high), bus (slave side).
module pipe_field_logic
  import pipe_field_pkg::*;
#(
  parameter int NUM_PIPES = 3,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int PIPE_W    = 60,
  parameter int SPACING   = 240,
  parameter int SPEED     = 2,
  parameter int GAP_H     = 120,
  parameter int GAP_MIN   = 60,
  parameter int GAP_BITS  = 7,
  parameter int BIRD_SIZE = 16
) (
  input logic               Clk,
  input logic               reset,
  pipe_field_logic_if.slave bus
);

  localparam logic signed [C_W-1:0] PW  = C_W'(PIPE_W);
  localparam logic signed [C_W-1:0] PWN = C_W'(-PIPE_W);
  localparam logic signed [C_W-1:0] SPD = C_W'(SPEED);
  localparam logic signed [C_W-1:0] BS  = C_W'(BIRD_SIZE);
  localparam logic signed [C_W-1:0] GH  = C_W'(GAP_H);
  localparam logic signed [C_W-1:0] SH  = C_W'(SCREEN_H);
  localparam logic signed [C_W-1:0] WRP =
    C_W'(NUM_PIPES * SPACING);
  localparam logic [Y_W-1:0] G_RST =
    Y_W'(GAP_MIN + 2**(GAP_BITS-1));

  state_e         st_q;
  logic           lose_q;
  logic [7:0]     score_q;
  logic [7:0]     score_d;
  logic [8:0]     sum;
  logic [3:0]     pass_cnt;
  logic           hit;
  logic [GAP_BITS-1:0] rnd;
  logic [Y_W-1:0] gap_new;
  logic [NUM_PIPES-1:0] hit_v;
  logic [NUM_PIPES-1:0] pass_v;
  logic signed [C_W-1:0] bx;
  logic signed [C_W-1:0] by;
  logic           step;
  logic           restore;

  pipe_lfsr #(.OUT_W(GAP_BITS)) u_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .en_i  (1'b1),
    .rnd_o (rnd)
  );

  assign bx      = {{2{bus.Bird_X[9]}}, bus.Bird_X};
  assign by      = {{2{bus.Bird_Y[9]}}, bus.Bird_Y};
  assign gap_new = Y_W'(GAP_MIN) + Y_W'(rnd);
  assign step    = (st_q == ST_RUN) && bus.Tick;
  assign restore = reset || ((st_q == ST_LOSE) && bus.Ack);

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    localparam logic [X_W-1:0] X_RST =
      X_W'(SCREEN_W + i * SPACING);

    logic [X_W-1:0]        x_q;
    logic [X_W-1:0]        xp_q;
    logic [Y_W-1:0]        g_q;
    logic signed [C_W-1:0] xs;
    logic signed [C_W-1:0] xps;
    logic signed [C_W-1:0] xdn;
    logic signed [C_W-1:0] gys;
    logic                  wrap;

    assign xs   = x_dec(x_q);
    assign xps  = x_dec(xp_q);
    assign xdn  = xs - SPD;
    assign wrap = xdn < PWN;
    assign gys  = {2'b00, g_q};

    assign hit_v[i] = (xs < bx + BS) && (xs + PW > bx) &&
                      ((by < gys) || (by + BS > gys + GH));
    // right edge crossed the bird's left edge on this Tick
    assign pass_v[i] = (xps + PW >= bx) && (xs + PW < bx);

    always_ff @(posedge Clk) begin
      if (restore) begin
        x_q  <= X_RST;
        xp_q <= X_RST;
        g_q  <= G_RST;
      end else if (step) begin
        xp_q <= x_q;
        x_q  <= X_W'(wrap ? xdn + WRP : xdn);
        if (wrap)
          g_q <= gap_new;
      end
    end

    assign bus.Pipe_X[11*i +: 11] = x_q;
    assign bus.Gap_Y[10*i +: 10]  = g_q;
  end

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++)
      pass_cnt = pass_cnt + 4'(pass_v[i]);
  end

  assign hit = (|hit_v) || (by < 0) || (by + BS >= SH);
  assign sum = {1'b0, score_q} + {5'b0, pass_cnt};
  assign score_d = sum[8] ? 8'hFF : sum[7:0];

  always_ff @(posedge Clk) begin
    if (reset) begin
      st_q    <= ST_INIT;
      score_q <= '0;
      lose_q  <= 1'b0;
    end else begin
      lose_q <= 1'b0;
      unique case (st_q)
        ST_INIT: begin
          score_q <= '0;
          if (bus.Start)
            st_q <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.Tick)
            st_q <= ST_CHECK;
        end
        ST_CHECK: begin
          if (hit) begin
            st_q   <= ST_LOSE;
            lose_q <= 1'b1;
          end else begin
            st_q    <= ST_RUN;
            score_q <= score_d;
          end
        end
        ST_LOSE: begin
          if (bus.Ack) begin
            st_q    <= ST_INIT;
            score_q <= '0;
          end
        end
        default: st_q <= ST_INIT;
      endcase
    end
  end

  assign bus.Q_Initial = st_q[0];
  assign bus.Q_Run     = st_q[1];
  assign bus.Q_Check   = st_q[2];
  assign bus.Q_Lose    = st_q[3];
  assign bus.Lose      = lose_q;
  assign bus.Score     = score_q;

endmodule

// File: tb/tb_pipe_field_logic.sv
// Bench for pipe_field_logic: integer game model compared
// every cycle, plus directed literal checks.
module tb_pipe_field_logic;

  localparam int NP = 3;

  logic Clk = 1'b0;
  logic reset = 1'b1;

  pipe_field_logic_if #(.NUM_PIPES(NP)) bus ();

  pipe_field_logic u_dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int nvec = 0;
  int nmis = 0;
  bit chk_en = 0;

  // model: 0 INIT, 1 RUN, 2 CHECK, 3 LOSE
  int m_st;
  int m_x[NP];
  int m_px[NP];
  int m_g[NP];
  int m_score;
  bit m_lose;
  bit [15:0] m_lfsr;

  function automatic void m_restore();
    for (int i = 0; i < NP; i++) begin
      m_x[i]  = 640 + i * 240;
      m_px[i] = m_x[i];
      m_g[i]  = 60 + 64;
    end
    m_score = 0;
  endfunction

  always @(posedge Clk) begin : model
    bit [15:0] nl;
    int bx, by, passes;
    bit hit;
    nl = {m_lfsr[14:0],
          m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    bx = int'(bus.Bird_X);
    by = int'(bus.Bird_Y);
    if (reset) begin
      m_st = 0;
      m_lose = 0;
      m_restore();
      nl = 16'hACE1;
    end else begin
      m_lose = 0;
      case (m_st)
        0: if (bus.Start) begin
          m_st = 1;
          m_score = 0;
        end
        1: if (bus.Tick) begin
          for (int i = 0; i < NP; i++) begin
            m_px[i] = m_x[i];
            m_x[i] = m_x[i] - 2;
            if (m_x[i] < -60) begin
              m_x[i] += 720;
              m_g[i] = 60 + int'(m_lfsr[6:0]);
            end
          end
          m_st = 2;
        end
        2: begin
          hit = (by < 0) || (by + 16 >= 480);
          passes = 0;
          for (int i = 0; i < NP; i++) begin
            if (m_x[i] < bx + 16 && m_x[i] + 60 > bx &&
                (by < m_g[i] || by + 16 > m_g[i] + 120))
              hit = 1;
            if (m_px[i] + 60 >= bx && m_x[i] + 60 < bx)
              passes++;
          end
          if (hit) begin
            m_st = 3;
            m_lose = 1;
          end else begin
            m_st = 1;
            m_score = m_score + passes;
            if (m_score > 255) m_score = 255;
          end
        end
        default: if (bus.Ack) begin
          m_st = 0;
          m_restore();
        end
      endcase
    end
    m_lfsr = nl;
  end

  always @(negedge Clk) begin : compare
    logic [3:0] ast, est;
    bit bad;
    if (chk_en) begin
      nvec++;
      bad = 0;
      ast = {bus.Q_Lose, bus.Q_Check, bus.Q_Run, bus.Q_Initial};
      est = 4'b0001 << m_st;
      if (ast != est || bus.Lose != m_lose ||
          int'(bus.Score) != m_score)
        bad = 1;
      for (int i = 0; i < NP; i++) begin
        if (bus.Pipe_X[11*i +: 11] != 11'(m_x[i]) ||
            int'(bus.Gap_Y[10*i +: 10]) != m_g[i])
          bad = 1;
      end
      if (bad) begin
        nmis++;
        $display("FAIL cycle t=%0t: st=%b/%b lose=%b/%b sc=%0d/%0d x0=%0d/%0d g0=%0d/%0d",
          $time, ast, est, bus.Lose, m_lose, bus.Score, m_score,
          bus.Pipe_X[10:0], 11'(m_x[0]), bus.Gap_Y[9:0], m_g[0]);
      end
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int px(input int i);
    return int'(bus.Pipe_X[11*i +: 11]);
  endfunction

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick(input bit see_check);
    bus.Tick = 1'b1;
    clk1();
    bus.Tick = 1'b0;
    if (see_check) chk("q_check", int'(bus.Q_Check), 1);
    clk1();
  endtask

  // keep the bird in the gap of whichever pipe it is inside
  task automatic steer_tick();
    for (int i = 0; i < NP; i++)
      if (m_x[i] - 2 < 336 && m_x[i] + 58 > 320)
        bus.Bird_Y = 10'(m_g[i] + 50);
    tick(0);
  endtask

  task automatic start_game();
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    bus.Start = 1'b1;
    clk1();
    bus.Start = 1'b0;
  endtask

  initial begin
    bus.Start = 0;
    bus.Ack = 0;
    bus.Tick = 0;
    bus.Bird_X = -10'sd200;
    bus.Bird_Y = 10'sd200;
    repeat (3) clk1();
    chk_en = 1;
    chk("rst_qinit", int'(bus.Q_Initial), 1);
    chk("rst_score", int'(bus.Score), 0);
    chk("rst_lose", int'(bus.Lose), 0);
    chk("rst_x0", px(0), 640);
    chk("rst_x1", px(1), 880);
    chk("rst_x2", px(2), 1120);
    chk("rst_g1", int'(bus.Gap_Y[19:10]), 124);
    reset = 1'b0;
    bus.Start = 1'b1;
    clk1();
    bus.Start = 1'b0;
    chk("start_qrun", int'(bus.Q_Run), 1);
    chk("start_x2", px(2), 1120);

    for (int k = 0; k < 10; k++) tick(1);
    chk("x0_10ticks", px(0), 620);
    chk("model_x0", m_x[0], 620);

    // Tick held across CHECK: only one step
    bus.Tick = 1'b1;
    clk1();
    clk1();
    bus.Tick = 1'b0;
    clk1();
    chk("tick_drop_x0", px(0), 618);

    for (int k = 0; k < 339; k++) tick(0);
    chk("x0_edge", int'(bus.Pipe_X[10:0] == 11'h7C4), 1);
    tick(0);
    chk("x0_respawn", px(0), 658);
    chk("g0_range", int'(bus.Gap_Y[9:0] >= 60 &&
                         bus.Gap_Y[9:0] <= 187), 1);

    // score: bird in initial gap at x=320
    bus.Bird_X = 10'sd320;
    bus.Bird_Y = 10'sd150;
    start_game();
    for (int k = 0; k < 190; k++) tick(0);
    chk("pre_pass_score", int'(bus.Score), 0);
    tick(0);
    chk("pass_score", int'(bus.Score), 1);
    chk("pass_x0", px(0), 258);

    // floor hit
    bus.Bird_Y = 10'sd470;
    bus.Tick = 1'b1;
    clk1();
    bus.Tick = 1'b0;
    chk("floor_check", int'(bus.Q_Check), 1);
    chk("floor_nolose", int'(bus.Lose), 0);
    clk1();
    chk("floor_lose", int'(bus.Lose), 1);
    chk("floor_qlose", int'(bus.Q_Lose), 1);
    chk("floor_score", int'(bus.Score), 1);
    clk1();
    chk("lose_pulse", int'(bus.Lose), 0);
    chk("lose_frozen", px(0), 256);
    bus.Ack = 1'b1;
    clk1();
    bus.Ack = 1'b0;
    chk("ack_qinit", int'(bus.Q_Initial), 1);
    chk("ack_score", int'(bus.Score), 0);
    chk("ack_x0", px(0), 640);

    // saturation
    bus.Bird_Y = 10'sd150;
    start_game();
    for (int k = 0; k < 30671; k++) steer_tick();
    chk("sat_255", int'(bus.Score), 255);
    for (int k = 0; k < 130; k++) steer_tick();
    chk("sat_hold", int'(bus.Score), 255);
    chk("sat_run", int'(bus.Q_Run), 1);

    // reset mid-game
    reset = 1'b1;
    clk1();
    reset = 1'b0;
    chk("rrun_qinit", int'(bus.Q_Initial), 1);
    chk("rrun_score", int'(bus.Score), 0);
    chk("rrun_x2", px(2), 1120);
    chk("rrun_g0", int'(bus.Gap_Y[9:0]), 124);
    clk1();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
